// File: rtl/button_press_classifier.sv
// Classifies debounced button presses by duration into short/long events.
// Counts press length in ms via an internal prescaler; all outputs are registered.
`timescale 1ns/1ps

module button_press_classifier #(
    parameter int TICKS_PER_MS = 50000,
    parameter int MIN_MS       = 2,
    parameter int LONG_MS      = 5000,
    parameter int MS_WIDTH     = 16
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_btn_level,
    output logic                o_short_pulse,
    output logic                o_long_pulse,
    output logic                o_hold,
    output logic                o_press_done,
    output logic [MS_WIDTH-1:0] o_press_ms
);

    localparam int                PS_WIDTH = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
    localparam logic [PS_WIDTH-1:0] PS_LAST  = PS_WIDTH'(TICKS_PER_MS - 1);
    localparam logic [MS_WIDTH-1:0] MS_MAX   = '1;
    localparam logic [MS_WIDTH-1:0] MIN_CNT  = MS_WIDTH'(MIN_MS);
    localparam logic [MS_WIDTH-1:0] LONG_CNT = MS_WIDTH'(LONG_MS);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_PRESSED   = 2'd1,
        S_LONG_HELD = 2'd2
    } state_t;

    function automatic logic [MS_WIDTH-1:0] sat_inc(input logic [MS_WIDTH-1:0] v);
        return (v == MS_MAX) ? v : v + MS_WIDTH'(1);
    endfunction

    state_t                r_state;
    logic                  r_btn_q;
    logic [PS_WIDTH-1:0]   r_prescale;
    logic [MS_WIDTH-1:0]   r_ms_cnt;
    logic                  r_short;
    logic                  r_long;
    logic                  r_hold;
    logic                  r_done;
    logic [MS_WIDTH-1:0]   r_press_ms;

    state_t                w_state_nxt;
    logic                  w_rise;
    logic                  w_fall;
    logic                  w_tick;
    logic [PS_WIDTH-1:0]   w_prescale_nxt;
    logic [MS_WIDTH-1:0]   w_ms_cnt_nxt;
    logic                  w_short_nxt;
    logic                  w_long_nxt;
    logic                  w_hold_nxt;
    logic                  w_done_nxt;
    logic [MS_WIDTH-1:0]   w_press_ms_nxt;

    assign w_rise = i_btn_level & ~r_btn_q;
    assign w_fall = ~i_btn_level & r_btn_q;
    assign w_tick = (r_prescale == PS_LAST);

    always_comb begin
        w_state_nxt    = r_state;
        w_prescale_nxt = r_prescale;
        w_ms_cnt_nxt   = r_ms_cnt;
        w_short_nxt    = 1'b0;
        w_long_nxt     = 1'b0;
        w_hold_nxt     = r_hold;
        w_done_nxt     = 1'b0;
        w_press_ms_nxt = r_press_ms;

        case (r_state)
            S_IDLE: begin
                w_hold_nxt = 1'b0;
                if (w_rise) begin
                    w_state_nxt    = S_PRESSED;
                    w_prescale_nxt = '0;
                    w_ms_cnt_nxt   = '0;
                end
            end

            S_PRESSED: begin
                if (w_fall) begin
                    // Release wins over a coincident tick; that tick is dropped.
                    w_state_nxt    = S_IDLE;
                    w_done_nxt     = 1'b1;
                    w_press_ms_nxt = r_ms_cnt;
                    w_short_nxt    = (r_ms_cnt >= MIN_CNT) && (r_ms_cnt < LONG_CNT);
                end else begin
                    w_prescale_nxt = w_tick ? '0 : r_prescale + PS_WIDTH'(1);
                    w_ms_cnt_nxt   = w_tick ? sat_inc(r_ms_cnt) : r_ms_cnt;
                    if (r_ms_cnt == LONG_CNT) begin
                        w_state_nxt = S_LONG_HELD;
                        w_long_nxt  = 1'b1;
                        w_hold_nxt  = 1'b1;
                    end
                end
            end

            S_LONG_HELD: begin
                if (w_fall) begin
                    w_state_nxt    = S_IDLE;
                    w_done_nxt     = 1'b1;
                    w_hold_nxt     = 1'b0;
                    w_press_ms_nxt = r_ms_cnt;
                end else begin
                    w_prescale_nxt = w_tick ? '0 : r_prescale + PS_WIDTH'(1);
                    w_ms_cnt_nxt   = w_tick ? sat_inc(r_ms_cnt) : r_ms_cnt;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_hold_nxt  = 1'b0;
            end
        endcase
    end

    // btn_q resets high so a button held through reset must be released before it counts.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state    <= S_IDLE;
            r_btn_q    <= 1'b1;
            r_prescale <= '0;
            r_ms_cnt   <= '0;
            r_short    <= 1'b0;
            r_long     <= 1'b0;
            r_hold     <= 1'b0;
            r_done     <= 1'b0;
            r_press_ms <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_btn_q    <= i_btn_level;
            r_prescale <= w_prescale_nxt;
            r_ms_cnt   <= w_ms_cnt_nxt;
            r_short    <= w_short_nxt;
            r_long     <= w_long_nxt;
            r_hold     <= w_hold_nxt;
            r_done     <= w_done_nxt;
            r_press_ms <= w_press_ms_nxt;
        end
    end

    assign o_short_pulse = r_short;
    assign o_long_pulse  = r_long;
    assign o_hold        = r_hold;
    assign o_press_done  = r_done;
    assign o_press_ms    = r_press_ms;

endmodule

// File: tb/tb_button_press_classifier.sv
// Bench for button_press_classifier: directed scenarios plus random presses
// checked cycle by cycle against an arithmetic press-length model.
`timescale 1ns/1ps

module tb_button_press_classifier;

    localparam int T   = 4;
    localparam int MIN = 2;
    localparam int L   = 10;

    logic       clk;
    logic       rst_n;
    logic       btn8, btn4;
    logic       s8, l8, h8, d8;
    logic [7:0] ms8;
    logic       s4, l4, h4, d4;
    logic [3:0] ms4;

    int         total;
    int         bad;
    int         press_id;
    int         cur_k;
    logic [7:0] last8;
    logic [7:0] last4;

    button_press_classifier #(.TICKS_PER_MS(T), .MIN_MS(MIN), .LONG_MS(L), .MS_WIDTH(8)) dut8 (
        .i_clk(clk), .i_reset(rst_n), .i_btn_level(btn8),
        .o_short_pulse(s8), .o_long_pulse(l8), .o_hold(h8),
        .o_press_done(d8), .o_press_ms(ms8)
    );

    button_press_classifier #(.TICKS_PER_MS(T), .MIN_MS(MIN), .LONG_MS(L), .MS_WIDTH(4)) dut4 (
        .i_clk(clk), .i_reset(rst_n), .i_btn_level(btn4),
        .o_short_pulse(s4), .o_long_pulse(l4), .o_hold(h4),
        .o_press_done(d4), .o_press_ms(ms4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s press=%0d k=%0d observed=%0d expected=%0d", tag, press_id, cur_k, obs, exp);
        end
    endtask

    task automatic step(input logic b8, input logic b4);
        btn8 = b8;
        btn4 = b4;
        @(posedge clk);
        #1;
    endtask

    // A press of n cycles high then g cycles low. Expected behaviour follows from
    // the press length alone: ms = floor((n-1)/T) saturated, long iff the held
    // level survives one edge past the LONG tick.
    task automatic press(input int sel, input int n, input int g, input bit tracked);
        int   maxv;
        int   ms;
        bit   lng, shrt;
        bit   b, e_long, e_hold, e_done, e_short;
        logic o_s, o_l, o_h, o_d;
        logic [7:0] o_ms, e_ms;
        press_id++;
        maxv = (sel == 4) ? 15 : 255;
        ms   = (n - 1) / T;
        if (ms > maxv) ms = maxv;
        lng  = (n >= L * T + 2);
        shrt = !lng && (ms >= MIN) && (ms < L);
        for (int k = 0; k < n + g; k++) begin
            cur_k = k;
            b = (k < n);
            if (sel == 4) step(1'b0, b);
            else          step(b, 1'b0);
            e_long  = tracked && lng && (k == L * T + 1);
            e_hold  = tracked && lng && (k >= L * T + 1) && (k <= n - 1);
            e_done  = tracked && (k == n);
            e_short = e_done && shrt;
            if (e_done) begin
                if (sel == 4) last4 = 8'(ms);
                else          last8 = 8'(ms);
            end
            if (sel == 4) begin
                o_s = s4; o_l = l4; o_h = h4; o_d = d4; o_ms = {4'b0, ms4}; e_ms = last4;
            end else begin
                o_s = s8; o_l = l8; o_h = h8; o_d = d8; o_ms = ms8; e_ms = last8;
            end
            chk("short_pulse", 8'(o_s), 8'(e_short));
            chk("long_pulse",  8'(o_l), 8'(e_long));
            chk("hold",        8'(o_h), 8'(e_hold));
            chk("press_done",  8'(o_d), 8'(e_done));
            chk("press_ms",    o_ms,    e_ms);
        end
    endtask

    initial begin
        int sel, n, g, cat;
        total    = 0;
        bad      = 0;
        press_id = 0;
        cur_k    = 0;
        last8    = 8'd0;
        last4    = 8'd0;
        btn8     = 1'b1;
        btn4     = 1'b0;
        rst_n    = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("rst_short8", 8'(s8), 8'd0);
        chk("rst_long8",  8'(l8), 8'd0);
        chk("rst_hold8",  8'(h8), 8'd0);
        chk("rst_done8",  8'(d8), 8'd0);
        chk("rst_ms8",    ms8,    8'd0);
        chk("rst_done4",  8'(d4), 8'd0);
        chk("rst_ms4",    {4'b0, ms4}, 8'd0);
        rst_n = 1'b1;

        // Button held through reset: ignored until released once.
        press(8, 100, 5, 1'b0);
        // Short, glitch, long, and the boundaries around the long threshold.
        press(8, 14, 3, 1'b1);
        press(8, 5, 3, 1'b1);
        press(8, 62, 3, 1'b1);
        press(8, 41, 2, 1'b1);
        press(8, 42, 1, 1'b1);
        press(8, 1, 1, 1'b1);
        press(8, 9, 1, 1'b1);
        // Saturation on the narrow counter.
        press(4, 200, 3, 1'b1);

        repeat (40) begin
            cat = $urandom_range(0, 3);
            case (cat)
                0:       n = $urandom_range(1, 8);
                1:       n = $urandom_range(9, 40);
                2:       n = $urandom_range(41, 43);
                default: n = $urandom_range(44, 90);
            endcase
            g   = $urandom_range(1, 5);
            sel = ($urandom_range(0, 1) == 1) ? 4 : 8;
            press(sel, n, g, 1'b1);
        end

        // Reset while in the long-held state, button still pressed.
        press_id++;
        for (int k = 0; k < 50; k++) step(1'b1, 1'b0);
        chk("pre_rst_hold", 8'(h8), 8'd1);
        rst_n = 1'b0;
        step(1'b1, 1'b0);
        rst_n = 1'b1;
        last8 = 8'd0;
        last4 = 8'd0;
        chk("midrst_hold",  8'(h8), 8'd0);
        chk("midrst_long",  8'(l8), 8'd0);
        chk("midrst_short", 8'(s8), 8'd0);
        chk("midrst_done",  8'(d8), 8'd0);
        chk("midrst_ms",    ms8,    8'd0);
        press(8, 10, 5, 1'b0);
        press(8, 14, 2, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
